// File: rtl/anita3_surf_l1_tx.sv
// anita3_surf_l1_tx: SURF-side L1 trigger pulse shaper with per-bit masking, holdoff and saturating scalers
module anita3_surf_l1_tx #(
    parameter int NUM_TRIG     = 4,
    parameter int WIDTH_BITS   = 4,
    parameter int HOLDOFF_BITS = 6,
    parameter int SCALER_BITS  = 16
) (
    input  logic                            clk250_i,
    input  logic                            rst_n_i,
    input  logic [NUM_TRIG-1:0]             trig_i,
    input  logic [NUM_TRIG-1:0]             mask_i,
    input  logic [WIDTH_BITS-1:0]           width_i,
    input  logic [HOLDOFF_BITS-1:0]         holdoff_i,
    input  logic                            scaler_latch_i,
    output logic [NUM_TRIG-1:0]             L1_o,
    output logic [NUM_TRIG*SCALER_BITS-1:0] scaler_o
);
    localparam int CW = (WIDTH_BITS > HOLDOFF_BITS) ? WIDTH_BITS : HOLDOFF_BITS;
    typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;
    state_t                 state_q [NUM_TRIG];
    state_t                 state_d [NUM_TRIG];
    logic [CW-1:0]          cnt_q [NUM_TRIG];
    logic [CW-1:0]          cnt_d [NUM_TRIG];
    logic [SCALER_BITS-1:0] count_q [NUM_TRIG];
    logic [SCALER_BITS-1:0] count_inc [NUM_TRIG];
    logic [NUM_TRIG-1:0]    trig_q, trig_qq, rise, enter;
    logic [CW-1:0]          w_load, h_load;
    assign rise   = trig_q & ~trig_qq;
    assign w_load = (width_i == '0) ? '0 : CW'(width_i) - 1'b1;
    assign h_load = CW'(holdoff_i) - 1'b1;
    always_comb begin
        enter = '0;
        for (int b = 0; b < NUM_TRIG; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b] - 1'b1;
            case (state_q[b])
                IDLE: begin
                    cnt_d[b] = w_load;
                    if (rise[b] && !mask_i[b]) begin
                        state_d[b] = FIRE;
                        enter[b]   = 1'b1;
                    end
                end
                FIRE: begin
                    if (mask_i[b])
                        state_d[b] = IDLE;
                    else if (cnt_q[b] == '0) begin
                        state_d[b] = (holdoff_i == '0) ? IDLE : HOLD;
                        cnt_d[b]   = h_load;
                    end
                end
                HOLD: state_d[b] = (mask_i[b] || cnt_q[b] == '0) ? IDLE : HOLD;
                default: state_d[b] = IDLE;
            endcase
            count_inc[b] = count_q[b] + SCALER_BITS'(enter[b] & ~&count_q[b]);
        end
    end
    // trig pipeline resets high so a level already asserted at release never looks like a rise
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trig_q   <= '1;
            trig_qq  <= '1;
            L1_o     <= '0;
            scaler_o <= '0;
            for (int b = 0; b < NUM_TRIG; b++) begin
                state_q[b] <= IDLE;
                cnt_q[b]   <= '0;
                count_q[b] <= '0;
            end
        end else begin
            trig_q  <= trig_i;
            trig_qq <= trig_q;
            for (int b = 0; b < NUM_TRIG; b++) begin
                L1_o[b]    <= (state_q[b] == FIRE) && !mask_i[b];
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
                count_q[b] <= scaler_latch_i ? '0 : count_inc[b];
                if (scaler_latch_i)
                    scaler_o[b*SCALER_BITS +: SCALER_BITS] <= count_inc[b];
            end
        end
    end
endmodule

// File: tb/tb_anita3_surf_l1_tx.sv
// tb_anita3_surf_l1_tx: directed bench for the L1 pulse shaper (8-bit scalers keep saturation runs short)
module tb_anita3_surf_l1_tx;
    localparam int SB = 8;
    logic          clk250_i = 1'b0;
    logic          rst_n_i;
    logic [3:0]    trig_i, mask_i, width_i;
    logic [5:0]    holdoff_i;
    logic          scaler_latch_i;
    logic [3:0]    L1_o;
    logic [4*SB-1:0] scaler_o;
    int            checks = 0;
    int            errors = 0;

    anita3_surf_l1_tx #(.SCALER_BITS(SB)) dut (
        .clk250_i(clk250_i), .rst_n_i(rst_n_i), .trig_i(trig_i), .mask_i(mask_i),
        .width_i(width_i), .holdoff_i(holdoff_i), .scaler_latch_i(scaler_latch_i),
        .L1_o(L1_o), .scaler_o(scaler_o)
    );

    always #2 clk250_i = ~clk250_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk250_i);
        #1;
    endtask

    task automatic latch();
        scaler_latch_i = 1'b1;
        tick(1);
        scaler_latch_i = 1'b0;
    endtask

    initial begin
        rst_n_i = 1'b1; trig_i = '0; mask_i = '0; width_i = 4'd3; holdoff_i = '0; scaler_latch_i = 1'b0;
        #1 rst_n_i = 1'b0;
        tick(2);
        check("rst_l1", 32'(L1_o), 32'h0);
        check("rst_scaler", scaler_o, 32'h0);
        rst_n_i = 1'b1;
        tick(2);
        // single pulse, width 3, level held 10 clocks
        trig_i[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            check($sformatf("w3_c%0d", c), 32'(L1_o[0]), 32'(c >= 2 && c <= 4));
        end
        trig_i[0] = 1'b0;
        tick(2);
        latch();
        check("w3_scaler", 32'(scaler_o[7:0]), 32'd1);
        // width 0 acts as width 1
        width_i = 4'd0;
        trig_i[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check($sformatf("w0_c%0d", c), 32'(L1_o[0]), 32'(c == 2));
        end
        trig_i[0] = 1'b0;
        // width 2, holdoff 4, rises at 0,3,9: rise at 3 lands in holdoff
        width_i = 4'd2; holdoff_i = 6'd4;
        tick(2);
        for (int c = 0; c < 14; c++) begin
            trig_i[1] = (c == 0 || c == 3 || c == 9);
            tick(1);
            check($sformatf("hold_c%0d", c), 32'(L1_o[1]), 32'(c == 2 || c == 3 || c == 11 || c == 12));
        end
        trig_i[1] = 1'b0;
        latch();
        check("hold_sc0", 32'(scaler_o[7:0]), 32'd1);
        check("hold_sc1", 32'(scaler_o[15:8]), 32'd2);
        // masked bit never fires
        width_i = 4'd1; holdoff_i = '0; mask_i = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            trig_i[2] = ~trig_i[2];
            tick(1);
            check($sformatf("mask_c%0d", c), 32'(L1_o[2]), 32'h0);
        end
        latch();
        check("mask_scaler", 32'(scaler_o[23:16]), 32'd0);
        // mask mid-pulse aborts to IDLE without holdoff
        mask_i = '0; width_i = 4'd8; holdoff_i = 6'd5;
        tick(2);
        trig_i[2] = 1'b1;
        tick(3);
        check("midmask_on", 32'(L1_o[2]), 32'h1);
        mask_i[2] = 1'b1;
        tick(1);
        check("midmask_cut", 32'(L1_o[2]), 32'h0);
        mask_i[2] = 1'b0;
        tick(1);
        check("midmask_idle", 32'(L1_o[2]), 32'h0);
        tick(2);
        check("midmask_idle2", 32'(L1_o[2]), 32'h0);
        latch();
        check("midmask_scaler", 32'(scaler_o[23:16]), 32'd1);
        // level held through reset release never fires
        width_i = 4'd3; holdoff_i = '0; trig_i = 4'hF;
        tick(2);
        rst_n_i = 1'b0;
        tick(2);
        rst_n_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check($sformatf("heldrst_c%0d", c), 32'(L1_o), 32'h0);
        end
        trig_i = 4'h0;
        tick(2);
        trig_i = 4'hF;
        tick(3);
        check("rearm_all", 32'(L1_o), 32'hF);
        // async reset mid-pulse
        rst_n_i = 1'b0;
        #1;
        check("async_l1", 32'(L1_o), 32'h0);
        check("async_scaler", scaler_o, 32'h0);
        tick(2);
        rst_n_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check($sformatf("postrst_c%0d", c), 32'(L1_o), 32'h0);
        end
        // saturation on bit 3
        trig_i = '0; width_i = 4'd1; holdoff_i = '0;
        tick(2);
        for (int i = 0; i < 300; i++) begin
            trig_i[3] = 1'b1;
            tick(1);
            trig_i[3] = 1'b0;
            tick(1);
        end
        tick(3);
        latch();
        check("sat_bit3", 32'(scaler_o[31:24]), 32'hFF);
        check("sat_others", 32'(scaler_o[23:0]), 32'h0);
        latch();
        check("sat_cleared", 32'(scaler_o[31:24]), 32'h0);
        // latch on the same edge as an entry: entry goes to scaler_o, not the new count
        for (int i = 0; i < 5; i++) begin
            trig_i[0] = 1'b1;
            tick(1);
            trig_i[0] = 1'b0;
            tick(1);
        end
        tick(2);
        trig_i[0] = 1'b1;
        tick(1);
        latch();
        check("same_edge", 32'(scaler_o[7:0]), 32'd6);
        trig_i[0] = 1'b0;
        tick(3);
        latch();
        check("same_edge_next", 32'(scaler_o[7:0]), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
